// File: rtl/demux8_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux8_reg
// Description : Registered 1-to-8 demultiplexer with valid/ready handshakes.
//               One single-entry buffer per destination channel.
// Revision    : 1.0 - initial release
// ============================================================================
module demux8_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic [2:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out0,
    output logic [N-1:0] out1,
    output logic [N-1:0] out2,
    output logic [N-1:0] out3,
    output logic [N-1:0] out4,
    output logic [N-1:0] out5,
    output logic [N-1:0] out6,
    output logic [N-1:0] out7,
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ready,
    output logic         busy
);

    logic [N-1:0] r_buf [8];
    logic [7:0]   r_full;
    logic         w_accept;

    // A full channel can still take a word when its consumer drains this cycle.
    assign in_ready = !r_full[in_sel] || out_ready[in_sel];
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_accept && (in_sel == 3'(i))) begin
                    r_buf[i]  <= in_data;
                    r_full[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    // Buffer keeps its stale word; only the flag clears.
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    assign out0      = r_buf[0];
    assign out1      = r_buf[1];
    assign out2      = r_buf[2];
    assign out3      = r_buf[3];
    assign out4      = r_buf[4];
    assign out5      = r_buf[5];
    assign out6      = r_buf[6];
    assign out7      = r_buf[7];
    assign out_valid = r_full;
    assign busy      = |r_full;

endmodule
`default_nettype wire

// File: tb/tb_demux8_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux8_reg
// Description : Self-checking bench for demux8_reg, directed and random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux8_reg;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] outs [8];
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    demux8_reg #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (outs[0]),
        .out1      (outs[1]),
        .out2      (outs[2]),
        .out3      (outs[3]),
        .out4      (outs[4]),
        .out5      (outs[5]),
        .out6      (outs[6]),
        .out7      (outs[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ready = 8'h00;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h2222_0002;
        cyc();
        in_sel = 3'd5; in_data = 32'h5555_0005;
        cyc();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 8'h24) begin
            n_fail++; $display("FAIL reset_preload: out_valid=%h expected=%h", out_valid, 8'h24);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: out_valid=%h busy=%b expected 00/0", out_valid, busy);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (outs[i] !== 32'h0) begin
                n_fail++; $display("FAIL reset_out%0d: got=%h expected=0", i, outs[i]);
            end
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_sel = 3'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset_ready sel=%0d: got=%b expected=1", i, in_ready);
            end
        end
        cyc();
    endtask

    task automatic test_routing();
        logic [31:0] exp_word;
        out_ready = 8'hFF;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                exp_word = 32'hA0 + 32'(i - 1);
                n_checks++;
                if (out_valid !== 8'(1 << (i - 1)) || outs[i-1] !== exp_word) begin
                    n_fail++;
                    $display("FAIL routing ch%0d: out_valid=%h data=%h expected %h/%h",
                             i - 1, out_valid, outs[i-1], 8'(1 << (i - 1)), exp_word);
                end
            end
            if (i < 8) begin
                in_valid = 1'b1; in_sel = 3'(i); in_data = 32'hA0 + 32'(i);
                #1;
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL routing_ready ch%0d: got=%b expected=1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc();
        end
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++; $display("FAIL routing_drain: out_valid=%h expected=00", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 8'hF7;
        in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h1111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_ready: got=%b expected=1", in_ready);
        end
        cyc();
        in_data = 32'h2222;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || outs[3] !== 32'h1111 || out_valid[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall c=%0d: ready=%b out3=%h v=%b expected 0/00001111/1",
                         c, in_ready, outs[3], out_valid[3]);
            end
            cyc();
        end
        out_ready = 8'hFF;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got=%b expected=1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (outs[3] !== 32'h2222 || out_valid[3] !== 1'b1) begin
            n_fail++; $display("FAIL bp_second: out3=%h v=%b expected 00002222/1", outs[3], out_valid[3]);
        end
        cyc();
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++; $display("FAIL bp_drain: out_valid=%h expected=00", out_valid);
        end
    endtask

    task automatic test_isolation();
        out_ready = 8'hBF;
        in_valid = 1'b1; in_sel = 3'd6; in_data = 32'h6666;
        cyc();
        in_sel = 3'd0; in_data = 32'h0100;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL iso_ready0: got=%b expected=1", in_ready);
        end
        cyc();
        in_sel = 3'd7; in_data = 32'h0700;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || outs[0] !== 32'h0100 || out_valid !== 8'h41) begin
            n_fail++;
            $display("FAIL iso_ch0: ready=%b out0=%h out_valid=%h expected 1/00000100/41",
                     in_ready, outs[0], out_valid);
        end
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (outs[7] !== 32'h0700 || outs[6] !== 32'h6666 || out_valid !== 8'hC0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL iso_ch7: out7=%h out6=%h out_valid=%h busy=%b expected 00000700/00006666/c0/1",
                     outs[7], outs[6], out_valid, busy);
        end
        out_ready = 8'hFF;
        cyc(); cyc();
        n_checks++;
        if (out_valid !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL iso_drain: out_valid=%h busy=%b expected 00/0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 8'hFF;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                n_checks++;
                if (out_valid[4] !== 1'b1 || outs[4] !== (32'hDEAD0000 + 32'(k - 1))) begin
                    n_fail++;
                    $display("FAIL stream k=%0d: v=%b out4=%h expected 1/%h",
                             k - 1, out_valid[4], outs[4], 32'hDEAD0000 + 32'(k - 1));
                end
            end
            if (k < 16) begin
                in_valid = 1'b1; in_sel = 3'd4; in_data = 32'hDEAD0000 + 32'(k);
                #1;
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL stream_ready k=%0d: got=%b expected=1", k, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc();
        end
    endtask

    task automatic test_random();
        logic [31:0] q [8][$];
        logic [31:0] last [8];
        logic [31:0] exp_out;
        logic [7:0]  exp_valid;
        logic        exp_ready;
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            last[i] = '0;
            q[i].delete();
        end
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = $urandom;
            out_ready = (c % 200 < 100) ? 8'($urandom) : 8'($urandom & $urandom);
            #1;
            exp_ready = (q[in_sel].size() == 0) || out_ready[in_sel];
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready c=%0d: got=%b expected=%b", c, in_ready, exp_ready);
            end
            for (int i = 0; i < 8; i++) exp_valid[i] = (q[i].size() != 0);
            n_checks++;
            if (out_valid !== exp_valid || busy !== (exp_valid != 0)) begin
                n_fail++;
                $display("FAIL rand_valid c=%0d: out_valid=%h busy=%b expected %h/%b",
                         c, out_valid, busy, exp_valid, exp_valid != 0);
            end
            for (int i = 0; i < 8; i++) begin
                exp_out = (q[i].size() != 0) ? q[i][0] : last[i];
                n_checks++;
                if (outs[i] !== exp_out) begin
                    n_fail++; $display("FAIL rand_data c=%0d ch%0d: got=%h expected=%h", c, i, outs[i], exp_out);
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (out_ready[i] && q[i].size() != 0) void'(q[i].pop_front());
            end
            if (in_valid && exp_ready) begin
                q[in_sel].push_back(in_data);
                last[in_sel] = in_data;
            end
            cyc();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_isolation();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
